// File: rtl/l2_cacheline_adaptor.sv
// L2 line <-> memory burst adaptor: splits a writeback line into BEATS beats and
// assembles BEATS read beats into a fill line, answering L2 with a single resp_o pulse.
module l2_cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [LINE_W-1:0]  wbuf_reg;
    logic [LINE_W-1:0]  line_reg;
    logic [BURST_W-1:0] burst_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               read_reg, write_reg, resp_reg;
    logic               start_any, start_wr;
    logic [BURST_W-1:0] wbeat [BEATS];
    logic               unused_addr_bits;

    // Byte offset within the line never reaches memory.
    assign unused_addr_bits = ^address_i[OFF_W-1:0];

    assign start_any = (state_reg == IDLE) && (read_i || write_i);
    assign start_wr  = (state_reg == IDLE) && write_i;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
            assign wbeat[gi] = wbuf_reg[gi*BURST_W +: BURST_W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (write_i) begin
                    state_next = WR;
                    cnt_next   = '0;
                end else if (read_i) begin
                    state_next = RD;
                    cnt_next   = '0;
                end
            end
            RD, WR: begin
                if (resp_i) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wbuf_reg  <= '0;
            line_reg  <= '0;
            burst_reg <= '0;
            addr_reg  <= '0;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            resp_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Strobes are registered from the next state so they line up with it.
            read_reg  <= (state_next == RD);
            write_reg <= (state_next == WR);
            resp_reg  <= (state_next == DONE);

            if (start_any) begin
                addr_reg <= {address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
            end

            if (start_wr) begin
                wbuf_reg  <= line_i;
                burst_reg <= line_i[BURST_W-1:0];
            end else if (state_reg == WR && resp_i && cnt_reg != LAST_BEAT) begin
                burst_reg <= wbeat[cnt_next];
            end

            if (state_reg == RD && resp_i) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (cnt_reg == CNT_W'(i)) begin
                        line_reg[i*BURST_W +: BURST_W] <= burst_i;
                    end
                end
            end
        end
    end

    assign line_o    = line_reg;
    assign burst_o   = burst_reg;
    assign address_o = addr_reg;
    assign read_o    = read_reg;
    assign write_o   = write_reg;
    assign resp_o    = resp_reg;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Bench for l2_cacheline_adaptor: directed table of line transfers, reset corner cases,
// then random transfers checked against a transaction-level model.
module tb_l2_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [255:0] last_line;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wline;
        logic [255:0] rdata;
        logic [15:0]  pat;
        logic [31:0]  exp_addr;
        logic         exp_wr;
    } vec_t;

    vec_t tbl [5];

    l2_cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One whole line transfer. pat[k] is resp_i in the k-th busy cycle; the model expects
    // address_o aligned, every beat of wline in order, line_o == rdata after a read and
    // unchanged after a write, and resp_o only in the cycle after the 4th beat.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [255:0] rdata,
                        input logic [15:0] pat, input logic [31:0] exp_addr,
                        input logic exp_wr);
        int beats = 0;
        int cyc = 0;
        logic [255:0] exp_line;
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = wline;
        resp_i    = 1'b1;               // stray strobe in IDLE must be ignored
        burst_i   = {2{$urandom}};
        step();
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = $urandom;           // changes after start must not leak through
        line_i    = {8{$urandom}};
        while (beats < 4 && cyc < 40) begin
            chk("address_o", address_o, exp_addr);
            chk("read_o busy", read_o, !exp_wr);
            chk("write_o busy", write_o, exp_wr);
            chk("resp_o busy", resp_o, 1'b0);
            if (exp_wr) chk("burst_o", burst_o, wline[64*beats +: 64]);
            resp_i  = (cyc >= 16) ? 1'b1 : pat[cyc % 16];
            burst_i = resp_i ? rdata[64*beats +: 64] : {2{$urandom}};
            if (resp_i) beats++;
            cyc++;
            step();
        end
        if (beats < 4) chk("beat budget", 256'(beats), 256'd4);
        exp_line = exp_wr ? last_line : rdata;
        resp_i   = 1'b1;                // ignored in DONE
        burst_i  = {2{$urandom}};
        chk("resp_o done", resp_o, 1'b1);
        chk("read_o done", read_o, 1'b0);
        chk("write_o done", write_o, 1'b0);
        chk("line_o done", line_o, exp_line);
        last_line = exp_line;
        step();
        resp_i = 1'b0;
        chk("resp_o idle", resp_o, 1'b0);
        chk("read_o idle", read_o, 1'b0);
        chk("write_o idle", write_o, 1'b0);
        chk("line_o idle", line_o, exp_line);
    endtask

    initial begin
        rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0; last_line = '0;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'h0,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                   16'hFFFF, 32'h0000_1220, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h8000_00FF,
                   {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                   256'h0, 16'h0039, 32'h8000_00E0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF,
                   256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0,
                   256'h0, 16'hFFFF, 32'hDEAD_BEE0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_0100,
                   256'h5A5A_0001_5A5A_0002_5A5A_0003_5A5A_0004_A5A5_0005_A5A5_0006_A5A5_0007_A5A5_0008,
                   256'h0, 16'hFFFF, 32'h0000_0100, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_205F, 256'h0,
                   256'hCAFE_0000_0000_0004_CAFE_0000_0000_0003_CAFE_0000_0000_0002_CAFE_0000_0000_0001,
                   16'h5555, 32'h0000_2040, 1'b0};

        // Reset state
        #12;
        chk("rst line_o", line_o, 256'h0);
        chk("rst burst_o", burst_o, 64'h0);
        chk("rst address_o", address_o, 32'h0);
        chk("rst read_o", read_o, 1'b0);
        chk("rst write_o", write_o, 1'b0);
        chk("rst resp_o", resp_o, 1'b0);
        step();
        rst = 1'b1;
        step();

        // Directed table; entries 3->4 are a writeback followed immediately by a fill.
        for (int i = 0; i < 5; i++) begin
            xfer(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wline, tbl[i].rdata,
                 tbl[i].pat, tbl[i].exp_addr, tbl[i].exp_wr);
        end

        // Reset after two read beats: silent abort, everything cleared immediately.
        read_i = 1'b1; address_i = 32'h0000_3000;
        step();
        read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h1;
        step();
        burst_i = 64'h2;
        step();
        #2 rst = 1'b0;
        #1;
        chk("abort line_o", line_o, 256'h0);
        chk("abort address_o", address_o, 32'h0);
        chk("abort read_o", read_o, 1'b0);
        chk("abort resp_o", resp_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort no resp_o", resp_o, 1'b0);
        end
        resp_i = 1'b0;
        rst = 1'b1;
        last_line = '0;
        step();
        xfer(1'b1, 1'b0, 32'h0000_3010, 256'h0,
             256'h9999_0000_0000_0004_9999_0000_0000_0003_9999_0000_0000_0002_9999_0000_0000_0001,
             16'hFFFF, 32'h0000_3000, 1'b0);

        // Random transfers against the model
        for (int n = 0; n < 24; n++) begin
            int kind;
            logic [31:0]  a;
            logic [255:0] wl, rdat;
            kind = $urandom_range(0, 2);
            a    = $urandom;
            wl   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rdat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            xfer(kind != 1, kind != 0, a, wl, rdat, 16'($urandom), a & ~32'h1F, kind != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
